// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, funct codes,
// ALU-op classes, ALU control codes and the main-control decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctl_t;

  // Subset of control carried across the ID/EX boundary (branch resolves in ID).
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
  } ex_ctl_t;

  function automatic ctl_t decode_main(input logic [5:0] opcode);
    ctl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: c = '{regdst: 1'b1, alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b1,
                      memread: 1'b0, memwrite: 1'b0, branch: 1'b0, aluop: ALUOP_RTYPE};
      OP_LW:    c = '{regdst: 1'b0, alusrc: 1'b1, memtoreg: 1'b1, regwrite: 1'b1,
                      memread: 1'b1, memwrite: 1'b0, branch: 1'b0, aluop: ALUOP_ADD};
      OP_SW:    c = '{regdst: 1'b0, alusrc: 1'b1, memtoreg: 1'b0, regwrite: 1'b0,
                      memread: 1'b0, memwrite: 1'b1, branch: 1'b0, aluop: ALUOP_ADD};
      OP_BEQ:   c = '{regdst: 1'b0, alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b0,
                      memread: 1'b0, memwrite: 1'b0, branch: 1'b1, aluop: ALUOP_SUB};
      OP_ADDI:  c = '{regdst: 1'b0, alusrc: 1'b1, memtoreg: 1'b0, regwrite: 1'b1,
                      memread: 1'b0, memwrite: 1'b0, branch: 1'b0, aluop: ALUOP_ADD};
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_decode_exec_if.sv
// Bus bundle between the ID/EX slice and its surroundings: instruction in,
// decoded control out, forwarded operands in, ALU results out.
interface mips_decode_exec_if #(parameter int W = 32);
  logic [31:0]  instr;
  logic         bubble;
  logic         regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc;
  logic [1:0]   aluop;
  logic         ex_regdst, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   ex_aluctl;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic         alu_ovf;

  modport master (
    output instr, bubble, op_a, op_b,
    input  regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc, aluop,
    input  ex_regdst, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite,
    input  ex_aluctl, alu_out, alu_zero, alu_ovf
  );

  modport slave (
    input  instr, bubble, op_a, op_b,
    output regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc, aluop,
    output ex_regdst, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite,
    output ex_aluctl, alu_out, alu_zero, alu_ovf
  );
endinterface

// File: rtl/mips_alu_core.sv
// Combinational W-bit ALU: logic ops, wrapping add/sub with signed overflow
// flag, and a full signed set-less-than.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]          ctl,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic [W-1:0]        out,
  output logic                zero,
  output logic                ovf
);

  logic signed [W-1:0] sum;
  logic signed [W-1:0] diff;
  logic                lt;

  assign sum  = a + b;
  assign diff = a - b;
  // Direct signed compare, so slt stays correct even when a-b would overflow.
  assign lt   = (a < b);

  always_comb begin
    out = '0;
    ovf = 1'b0;
    case (ctl)
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_ADD: begin
        out = sum;
        ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        out = diff;
        ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      ALU_SLT: out = {{(W-1){1'b0}}, lt};
      ALU_NOR: out = ~(a | b);
      ALU_XOR: out = a ^ b;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/mips_decode_exec.sv
// ID-stage main control decode, ID/EX control register, and EX-stage ALU
// control decode driving the ALU core.
module mips_decode_exec
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mips_decode_exec_if.slave bus
);

  function automatic logic [3:0] alu_ctl_decode(input logic [1:0] aluop,
                                                input logic [5:0] funct);
    logic [3:0] c;
    c = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   c = ALU_ADD;
      ALUOP_SUB:   c = ALU_SUB;
      ALUOP_RSVD:  c = ALU_ADD;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  c = ALU_ADD;
          FN_SUB:  c = ALU_SUB;
          FN_AND:  c = ALU_AND;
          FN_OR:   c = ALU_OR;
          FN_XOR:  c = ALU_XOR;
          FN_NOR:  c = ALU_NOR;
          FN_SLT:  c = ALU_SLT;
          default: c = ALU_ADD;
        endcase
      end
      default:     c = ALU_ADD;
    endcase
    return c;
  endfunction

  ctl_t                id_ctl_p0;
  ex_ctl_t             ex_ctl_p0;
  logic signed [W-1:0] seimm_p0;

  ex_ctl_t             ctl_p1;
  logic [5:0]          funct_p1;
  logic signed [W-1:0] seimm_p1;

  logic [3:0]          aluctl_p1;
  logic signed [W-1:0] alu_b_p1;
  logic                unused_instr;

  // ---- ID stage: combinational decode ----
  assign id_ctl_p0 = decode_main(bus.instr[31:26]);
  assign seimm_p0  = {{(W-16){bus.instr[15]}}, bus.instr[15:0]};

  assign ex_ctl_p0 = bus.bubble ? '0 :
                     '{regdst:   id_ctl_p0.regdst,
                       alusrc:   id_ctl_p0.alusrc,
                       memtoreg: id_ctl_p0.memtoreg,
                       regwrite: id_ctl_p0.regwrite,
                       memread:  id_ctl_p0.memread,
                       memwrite: id_ctl_p0.memwrite,
                       aluop:    id_ctl_p0.aluop};

  assign bus.regdst   = id_ctl_p0.regdst;
  assign bus.alusrc   = id_ctl_p0.alusrc;
  assign bus.memtoreg = id_ctl_p0.memtoreg;
  assign bus.regwrite = id_ctl_p0.regwrite;
  assign bus.memread  = id_ctl_p0.memread;
  assign bus.memwrite = id_ctl_p0.memwrite;
  assign bus.branch   = id_ctl_p0.branch;
  assign bus.aluop    = id_ctl_p0.aluop;

  // Register fields are decoded elsewhere in the pipeline.
  assign unused_instr = ^bus.instr[25:6];

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_p1   <= '0;
      funct_p1 <= '0;
      seimm_p1 <= '0;
    end else begin
      ctl_p1   <= ex_ctl_p0;
      funct_p1 <= bus.instr[5:0];
      seimm_p1 <= seimm_p0;
    end
  end

  // ---- EX stage: ALU control and ALU ----
  assign aluctl_p1 = alu_ctl_decode(ctl_p1.aluop, funct_p1);
  assign alu_b_p1  = ctl_p1.alusrc ? seimm_p1 : $signed(bus.op_b);

  assign bus.ex_regdst   = ctl_p1.regdst;
  assign bus.ex_memread  = ctl_p1.memread;
  assign bus.ex_memwrite = ctl_p1.memwrite;
  assign bus.ex_memtoreg = ctl_p1.memtoreg;
  assign bus.ex_regwrite = ctl_p1.regwrite;
  assign bus.ex_aluctl   = aluctl_p1;

  mips_alu_core #(.W(W)) u_alu (
    .ctl  (aluctl_p1),
    .a    ($signed(bus.op_a)),
    .b    (alu_b_p1),
    .out  (bus.alu_out),
    .zero (bus.alu_zero),
    .ovf  (bus.alu_ovf)
  );

endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed bench for mips_decode_exec: decode, ID/EX register, bubble,
// async reset and the ALU function set with hand-computed expectations.
module tb_mips_decode_exec;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mips_decode_exec_if #(.W(32)) bus ();

  mips_decode_exec #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] id_ctl();
    return {bus.regdst, bus.alusrc, bus.memtoreg, bus.regwrite,
            bus.memread, bus.memwrite, bus.branch, bus.aluop};
  endfunction

  function automatic logic [4:0] ex_ctl();
    return {bus.ex_regdst, bus.ex_memread, bus.ex_memwrite,
            bus.ex_memtoreg, bus.ex_regwrite};
  endfunction

  task automatic rtype(input logic [5:0] funct);
    bus.instr = 32'h012A4000 | {26'd0, funct};
    step();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.instr  = 32'h0;
    bus.bubble = 1'b0;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;
    step();
    step();
    #1;
    chk("reset_ex_ctl", {27'd0, ex_ctl()}, 32'h0);
    chk("reset_aluctl", {28'd0, bus.ex_aluctl}, 32'h2);
    @(negedge clk);
    rst = 1'b0;

    // R-type add
    bus.instr = 32'h012A4020;
    #1;
    chk("rtype_id_ctl", {23'd0, id_ctl()}, {23'd0, 9'b1_0_0_1_0_0_0_10});
    step();
    bus.op_a = 32'h7FFFFFFF;
    bus.op_b = 32'h00000001;
    #1;
    chk("rtype_ex_ctl", {27'd0, ex_ctl()}, {27'd0, 5'b10001});
    chk("rtype_aluctl", {28'd0, bus.ex_aluctl}, 32'h2);
    chk("add_ovf_out", bus.alu_out, 32'h80000000);
    chk("add_ovf_flag", {31'd0, bus.alu_ovf}, 32'h1);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #1;
    chk("pre_reset_regwrite", {31'd0, bus.ex_regwrite}, 32'h1);
    rst = 1'b1;
    bus.op_a = 32'd5;
    bus.op_b = 32'd7;
    #1;
    chk("async_reset_ex_ctl", {27'd0, ex_ctl()}, 32'h0);
    chk("async_reset_aluctl", {28'd0, bus.ex_aluctl}, 32'h2);
    chk("async_reset_sum", bus.alu_out, 32'd12);
    @(negedge clk);
    rst = 1'b0;

    // lw with negative offset
    bus.instr = 32'h8D28FFFC;
    #1;
    chk("lw_id_ctl", {23'd0, id_ctl()}, {23'd0, 9'b0_1_1_1_1_0_0_00});
    step();
    bus.op_a = 32'h00000100;
    bus.op_b = 32'hDEADBEEF;
    #1;
    chk("lw_ex_ctl", {27'd0, ex_ctl()}, {27'd0, 5'b01011});
    chk("lw_addr", bus.alu_out, 32'h000000FC);
    chk("lw_zero", {31'd0, bus.alu_zero}, 32'h0);
    chk("lw_ovf", {31'd0, bus.alu_ovf}, 32'h0);

    // sw with and without bubble
    bus.instr  = 32'hAD28FFFC;
    bus.bubble = 1'b1;
    #1;
    chk("sw_id_ctl", {23'd0, id_ctl()}, {23'd0, 9'b0_1_0_0_0_1_0_00});
    step();
    #1;
    chk("bubble_ex_ctl", {27'd0, ex_ctl()}, 32'h0);
    chk("bubble_aluctl", {28'd0, bus.ex_aluctl}, 32'h2);
    chk("bubble_alusrc_off", bus.alu_out, 32'h00000100 + 32'hDEADBEEF);
    bus.bubble = 1'b0;
    step();
    #1;
    chk("sw_ex_ctl", {27'd0, ex_ctl()}, {27'd0, 5'b00100});
    chk("sw_addr", bus.alu_out, 32'h000000FC);

    // Funct sweep with a=-3, b=2
    bus.op_a = 32'hFFFFFFFD;
    bus.op_b = 32'h00000002;
    rtype(6'h2A); chk("slt", bus.alu_out, 32'h1);
                  chk("slt_aluctl", {28'd0, bus.ex_aluctl}, 32'h7);
    rtype(6'h22); chk("sub", bus.alu_out, 32'hFFFFFFFB);
                  chk("sub_ovf", {31'd0, bus.alu_ovf}, 32'h0);
    rtype(6'h24); chk("and", bus.alu_out, 32'h0);
                  chk("and_zero", {31'd0, bus.alu_zero}, 32'h1);
    rtype(6'h25); chk("or", bus.alu_out, 32'hFFFFFFFF);
    rtype(6'h27); chk("nor", bus.alu_out, 32'h0);
    rtype(6'h26); chk("xor", bus.alu_out, 32'hFFFFFFFF);
                  chk("xor_aluctl", {28'd0, bus.ex_aluctl}, 32'hD);
    rtype(6'h20); chk("add", bus.alu_out, 32'hFFFFFFFF);
    rtype(6'h3F); chk("unknown_funct", bus.alu_out, 32'hFFFFFFFF);
                  chk("unknown_funct_aluctl", {28'd0, bus.ex_aluctl}, 32'h2);

    // slt across the signed range, sub overflow
    bus.op_a = 32'h80000000;
    bus.op_b = 32'h7FFFFFFF;
    rtype(6'h2A); chk("slt_extreme", bus.alu_out, 32'h1);
    bus.op_b = 32'h00000001;
    rtype(6'h22); chk("sub_ovf_out", bus.alu_out, 32'h7FFFFFFF);
                  chk("sub_ovf_flag", {31'd0, bus.alu_ovf}, 32'h1);

    // beq
    bus.instr = 32'h11090003;
    #1;
    chk("beq_id_ctl", {23'd0, id_ctl()}, {23'd0, 9'b0_0_0_0_0_0_1_01});
    step();
    bus.op_a = 32'h00001234;
    bus.op_b = 32'h00001234;
    #1;
    chk("beq_aluctl", {28'd0, bus.ex_aluctl}, 32'h6);
    chk("beq_zero", {31'd0, bus.alu_zero}, 32'h1);
    chk("beq_ex_ctl", {27'd0, ex_ctl()}, 32'h0);

    // Unknown opcode
    bus.instr = 32'hFC000000;
    #1;
    chk("nop_id_ctl", {23'd0, id_ctl()}, 32'h0);
    step();
    #1;
    chk("nop_aluctl", {28'd0, bus.ex_aluctl}, 32'h2);

    // addi with -1 immediate
    bus.instr = 32'h2108FFFF;
    #1;
    chk("addi_id_ctl", {23'd0, id_ctl()}, {23'd0, 9'b0_1_0_1_0_0_0_00});
    step();
    bus.op_a = 32'h00000001;
    #1;
    chk("addi_out", bus.alu_out, 32'h0);
    chk("addi_zero", {31'd0, bus.alu_zero}, 32'h1);
    chk("addi_ovf", {31'd0, bus.alu_ovf}, 32'h0);
    chk("addi_ex_ctl", {27'd0, ex_ctl()}, {27'd0, 5'b00001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
